// File: rtl/cmp_flag_gen.sv
// Qualified compare-flag generator: registered raw compare result plus a
// run-length qualified (optionally sticky) flag.
module cmp_flag_gen #(
  parameter int WIDTH = 32,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             sticky,
  input  logic             clr,
  output logic             raw,
  output logic             out,
  output logic [CNT_W-1:0] run_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ACTIVE  = 2'd2,
    LATCHED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD);
  localparam bit               HOLD_ONE = (HOLD == 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_raw;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_cond;
  logic             w_reached;
  logic             w_out_nxt;

  always_comb begin
    w_cond = 1'b0;
    unique case (mode)
      3'd0: w_cond = (a == b);
      3'd1: w_cond = (a != b);
      3'd2: w_cond = (a < b);
      3'd3: w_cond = ($signed(a) < $signed(b));
      3'd4: w_cond = (a >= b);
      3'd5: w_cond = ($signed(a) >= $signed(b));
      3'd6: w_cond = (a == '0);
      3'd7: w_cond = (a != '0);
    endcase
  end

  // Saturating increment: the counter parks at all-ones instead of wrapping
  assign w_cnt_sat = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
  assign w_reached = (w_cnt_sat >= HOLD_C);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_cond && HOLD_ONE) w_state_nxt = ACTIVE;
        else if (w_cond)        w_state_nxt = QUAL;
      end
      QUAL: begin
        if (!w_cond)        w_state_nxt = IDLE;
        else if (w_reached) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!w_cond && sticky)  w_state_nxt = LATCHED;
        else if (!w_cond)       w_state_nxt = IDLE;
      end
      LATCHED: w_state_nxt = LATCHED;
    endcase
  end

  assign w_out_nxt = (w_state_nxt == ACTIVE) ||
                     (w_state_nxt == LATCHED);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_raw   <= 1'b0;
      r_out   <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cond ? w_cnt_sat : '0;
      r_raw   <= w_cond;
      r_out   <= w_out_nxt;
    end
  end

  assign raw     = r_raw;
  assign out     = r_out;
  assign run_cnt = r_cnt;

endmodule

// File: tb/tb_cmp_flag_gen.sv
// Bench for cmp_flag_gen: three parameterisations checked every cycle
// against a run-length reference model, directed steps then random.
module tb_cmp_flag_gen;

  logic        clk = 1'b0;
  logic        reset, en, sticky, clr;
  logic [31:0] a, b;
  logic [2:0]  mode;

  logic       raw0, out0;
  logic [7:0] cnt0;
  logic       raw1, out1;
  logic [2:0] cnt1;
  logic       raw2, out2;
  logic [7:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  int hold_p[3] = '{4, 2, 1};
  int cmax_p[3] = '{255, 7, 255};
  int m_run[3];
  bit m_lat[3];
  bit m_raw;

  always #5 clk = ~clk;

  cmp_flag_gen #(.WIDTH(32), .HOLD(4), .CNT_W(8)) u_d0 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .mode(mode),
    .sticky(sticky), .clr(clr), .raw(raw0), .out(out0), .run_cnt(cnt0));

  cmp_flag_gen #(.WIDTH(32), .HOLD(2), .CNT_W(3)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .mode(mode),
    .sticky(sticky), .clr(clr), .raw(raw1), .out(out1), .run_cnt(cnt1));

  cmp_flag_gen #(.WIDTH(32), .HOLD(1), .CNT_W(8)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .mode(mode),
    .sticky(sticky), .clr(clr), .raw(raw2), .out(out2), .run_cnt(cnt2));

  function automatic bit ref_cond(input logic [31:0] x, input logic [31:0] y,
                                  input logic [2:0] m);
    int signed sx, sy;
    sx = x;
    sy = y;
    case (m)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return x < y;
      3'd3: return sx < sy;
      3'd4: return x >= y;
      3'd5: return sx >= sy;
      3'd6: return x == 0;
      default: return x != 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit c, act;
    if (reset || clr) begin
      m_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0;
        m_lat[i] = 1'b0;
      end
    end else if (en) begin
      c = ref_cond(a, b, mode);
      m_raw = c;
      for (int i = 0; i < 3; i++) begin
        act = !m_lat[i] && (m_run[i] >= hold_p[i]);
        if (act && !c && sticky) m_lat[i] = 1'b1;
        m_run[i] = c ? m_run[i] + 1 : 0;
      end
    end
  endtask

  function automatic int exp_cnt(input int i);
    return (m_run[i] > cmax_p[i]) ? cmax_p[i] : m_run[i];
  endfunction

  function automatic bit exp_out(input int i);
    return m_lat[i] || (m_run[i] >= hold_p[i]);
  endfunction

  task automatic check_all();
    chk("raw_h4", 32'(raw0), 32'(m_raw));
    chk("out_h4", 32'(out0), 32'(exp_out(0)));
    chk("cnt_h4", 32'(cnt0), 32'(exp_cnt(0)));
    chk("raw_h2", 32'(raw1), 32'(m_raw));
    chk("out_h2", 32'(out1), 32'(exp_out(1)));
    chk("cnt_h2", 32'(cnt1), 32'(exp_cnt(1)));
    chk("raw_h1", 32'(raw2), 32'(m_raw));
    chk("out_h1", 32'(out2), 32'(exp_out(2)));
    chk("cnt_h1", 32'(cnt2), 32'(exp_cnt(2)));
  endtask

  // Drive at negedge, model the posedge, check #1 after it
  task automatic cyc(input bit r, input bit e, input bit c, input bit s,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [2:0] m);
    reset  = r;
    en     = e;
    clr    = c;
    sticky = s;
    a      = x;
    b      = y;
    mode   = m;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  logic [3:0] mode_exp;
  bit         pat[8];
  logic [2:0] rmode;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; sticky = 1'b0;
    a = '0; b = '0; mode = 3'd6;
    m_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_lat[i] = 1'b0;
    end
    @(negedge clk);

    // Reset for two cycles, then release with en low
    cyc(1, 1, 0, 0, 0, 0, 6);
    cyc(1, 1, 0, 0, 0, 0, 6);
    chk("rst_raw", 32'(raw0), 0);
    chk("rst_out", 32'(out0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    cyc(0, 0, 0, 0, 0, 0, 6);
    chk("post_rst_out", 32'(out0), 0);

    // EQ true for 4 cycles with HOLD=4
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 32'h1234, 32'h1234, 0);
      chk("eq_run_cnt", 32'(cnt0), i + 1);
      chk("eq_run_out", 32'(out0), (i == 3) ? 1 : 0);
      chk("eq_run_raw", 32'(raw0), 1);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);

    // 3 true, 1 false, 4 true
    pat = '{1, 1, 1, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 32'h55, pat[i] ? 32'h55 : 32'h56, 0);
      chk("brk_out", 32'(out0), (i == 7) ? 1 : 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Sticky latch, clear, then clr beats a true cond
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 7, 7, 0);
    cyc(0, 1, 0, 1, 7, 8, 0);
    chk("latched_out", 32'(out0), 1);
    cyc(0, 1, 0, 0, 7, 8, 0);
    chk("latched_hold", 32'(out0), 1);
    cyc(0, 1, 1, 1, 7, 7, 0);
    chk("clr_out", 32'(out0), 0);
    chk("clr_cnt", 32'(cnt0), 0);
    chk("clr_raw", 32'(raw0), 0);

    // Signed vs unsigned compares: LTU, LTS, GEU, GES
    mode_exp = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 32'hFFFF_FFFF, 1, 3'(2 + i));
      chk("cmp_raw", 32'(raw0), 32'(mode_exp[i]));
    end
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Saturation of the 3-bit counter with en toggling
    for (int i = 0; i < 20; i++)
      cyc(0, (i % 2) == 0, 0, 0, 5, 0, 7);
    chk("sat_cnt", 32'(cnt1), 7);
    cyc(0, 0, 0, 0, 5, 0, 7);
    chk("sat_hold", 32'(cnt1), 7);
    cyc(1, 1, 0, 0, 5, 0, 7);
    chk("midrst_cnt", 32'(cnt1), 0);
    chk("midrst_out", 32'(out1), 0);

    // Randomised traffic against the reference model
    rmode = 3'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rmode = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'hFFFF_FFFF; rb = $urandom_range(0, 2); end
        default: begin
          ra = $urandom_range(0, 2);
          rb = $urandom_range(0, 2);
        end
      endcase
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
          ra, rb, rmode);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
